// File: rtl/boreal_replay_checker.sv
// Replay checker: records ledger entries into a golden buffer, then compares a replayed stream against it.
// Optional build macro BOREAL_REPLAY_MASK_EN adds the per-word compare MASK register at 0x1C.
module boreal_replay_checker #(
  parameter int ENTRY_WORDS = 8,
  parameter int DEPTH       = 16,
  parameter int WI_W        = $clog2(ENTRY_WORDS),
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [31:0] ent_word,
  input  logic        ent_last,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mismatch,
  output logic        done
);

  localparam int DI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, COMPARE = 2'd2} state_t;

  state_t state, state_d;

  logic [31:0]      gold [0:DEPTH-1][0:ENTRY_WORDS-1];
  logic [WI_W-1:0]  wi;
  logic [CNT_W-1:0] rec_count, cmp_count, cmp_next;
  logic             overflow, framing;
  logic [7:0]       mm_entry, mm_word;
  logic [31:0]      mm_gold, mm_now;
  logic [15:0]      gold_addr;
  logic [5:0]       off;
  logic             wi_at_end, entry_end, frame_bad, rec_full;
  logic             ctrl_wr, word_masked, cmp_diff, gold_in_range;
  logic [31:0]      gold_cmp, gold_rd, rd_data;
  logic             rd_err;
  logic             unused_bits;

`ifdef BOREAL_REPLAY_MASK_EN
  logic [ENTRY_WORDS-1:0] mask;
  assign word_masked = mask[wi];
`else
  assign word_masked = 1'b0;
`endif

  assign ent_ready   = 1'b1;
  assign unused_bits = ^{req_addr[1:0], req_wdata[31:16]};

  assign off       = req_addr[7:2];
  assign ctrl_wr   = req_valid && req_we && (off == 6'd0);
  assign wi_at_end = (wi == WI_W'(ENTRY_WORDS - 1));
  assign entry_end = ent_valid && (ent_last || wi_at_end);
  assign frame_bad = ent_valid && (ent_last != wi_at_end);
  assign rec_full  = (rec_count >= CNT_W'(DEPTH));
  assign cmp_next  = cmp_count + CNT_W'(1);
  assign gold_cmp  = gold[cmp_count[DI_W-1:0]][wi];
  assign cmp_diff  = (ent_word != gold_cmp) && !word_masked;

  assign gold_in_range = ({24'b0, gold_addr[15:8]} < 32'(DEPTH)) &&
                         ({24'b0, gold_addr[7:0]} < 32'(ENTRY_WORDS));
  assign gold_rd = gold_in_range ? gold[gold_addr[8 +: DI_W]][gold_addr[0 +: WI_W]] : 32'h0;

  // Stream word is handled under the current state; a CTRL write then overrides the transition.
  always_comb begin
    state_d = state;
    if (state == COMPARE && entry_end && cmp_next == rec_count)
      state_d = IDLE;
    if (ctrl_wr) begin
      if (req_wdata[2])
        state_d = IDLE;
      else if (state == IDLE) begin
        if (req_wdata[0])
          state_d = RECORD;
        else if (req_wdata[1] && rec_count != '0)
          state_d = COMPARE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b0;
    case (off)
      6'd0: rd_data = 32'h0;
      6'd1: rd_data = {26'b0, framing, overflow, done, mismatch, state};
      6'd2: rd_data = 32'(rec_count);
      6'd3: rd_data = 32'(cmp_count);
      6'd4: rd_data = {16'b0, mm_entry, mm_word};
      6'd5: rd_data = mm_gold;
      6'd6: rd_data = mm_now;
`ifdef BOREAL_REPLAY_MASK_EN
      6'd7: rd_data = 32'(mask);
`endif
      6'd8: rd_data = {16'b0, gold_addr};
      6'd9: rd_data = gold_rd;
      default: rd_err = 1'b1;
    endcase
  end

  // Golden buffer has no reset so a recording survives rst for later replay.
  always_ff @(posedge clk) begin
    if (!rst && state == RECORD && ent_valid && !rec_full)
      gold[rec_count[DI_W-1:0]][wi] <= ent_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wi         <= '0;
      rec_count  <= '0;
      cmp_count  <= '0;
      overflow   <= 1'b0;
      framing    <= 1'b0;
      mismatch   <= 1'b0;
      done       <= 1'b0;
      mm_entry   <= '0;
      mm_word    <= '0;
      mm_gold    <= '0;
      mm_now     <= '0;
      gold_addr  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef BOREAL_REPLAY_MASK_EN
      mask       <= '0;
`endif
    end else begin
      if (ent_valid)
        wi <= entry_end ? '0 : wi + WI_W'(1);
      if (frame_bad)
        framing <= 1'b1;

      case (state)
        RECORD: if (ent_valid) begin
          if (!rec_full) begin
            if (entry_end) rec_count <= rec_count + CNT_W'(1);
          end else
            overflow <= 1'b1;
        end
        COMPARE: if (ent_valid) begin
          if (cmp_diff && !mismatch) begin
            mismatch <= 1'b1;
            mm_entry <= 8'(cmp_count);
            mm_word  <= 8'(wi);
            mm_gold  <= gold_cmp;
            mm_now   <= ent_word;
          end
          if (entry_end) begin
            cmp_count <= cmp_next;
            if (cmp_next == rec_count) done <= 1'b1;
          end
        end
        default: ;
      endcase

      // Start commands clear state after the stream word so their clears win.
      if (ctrl_wr && !req_wdata[2] && state == IDLE) begin
        if (req_wdata[0]) begin
          rec_count <= '0;
          overflow  <= 1'b0;
          framing   <= 1'b0;
        end else if (req_wdata[1]) begin
          cmp_count <= '0;
          mismatch  <= 1'b0;
          done      <= (rec_count == '0);
          mm_entry  <= '0;
          mm_word   <= '0;
          mm_gold   <= '0;
          mm_now    <= '0;
          framing   <= 1'b0;
        end
      end

      if (req_valid && req_we && off == 6'd8)
        gold_addr <= req_wdata[15:0];
`ifdef BOREAL_REPLAY_MASK_EN
      if (req_valid && req_we && off == 6'd7)
        mask <= req_wdata[ENTRY_WORDS-1:0];
`endif

      resp_valid <= req_valid;
      resp_err   <= req_valid && rd_err;
      resp_rdata <= (req_valid && !req_we && !rd_err) ? rd_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_boreal_replay_checker.sv
// Directed bench for boreal_replay_checker: register-map vector table plus record/compare scenarios.
// Mask checks follow BOREAL_REPLAY_MASK_EN as defined for the build.
module tb_boreal_replay_checker;

  localparam int EW  = 8;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ent_valid, ent_ready, ent_last;
  logic [31:0] ent_word;
  logic        req_valid, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err, mismatch, done;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  boreal_replay_checker #(.ENTRY_WORDS(EW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_word(ent_word), .ent_last(ent_last),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mismatch(mismatch), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic we, logic [7:0] a, logic [31:0] wd,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic mmio(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    check_output("resp_valid", 32'(resp_valid), 32'h1);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e;
    mmio(1'b1, addr, data, d, e);
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic e;
    mmio(1'b0, addr, 32'h0, d, e);
    check_output(name, d, exp);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    ent_valid = 1'b1; ent_word = w; ent_last = last;
    @(posedge clk); #1;
    ent_valid = 1'b0; ent_last = 1'b0;
  endtask

  // Sends a full entry of base+i; word bad_idx (if < EW) is replaced by bad_val.
  task automatic send_entry(input logic [31:0] base, input int bad_idx, input logic [31:0] bad_val);
    for (int i = 0; i < EW; i++)
      send_word((i == bad_idx) ? bad_val : base + 32'(i), i == EW - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] d; logic e;
    mmio(v.we, v.addr, v.wdata, d, e);
    check_output({v.name, "_rdata"}, d, v.exp_rdata);
    check_output({v.name, "_err"}, 32'(e), 32'(v.exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ent_ready"}, 32'(ent_ready), 32'h1);
    check_output({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check_output({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check_output({tag, "_resp_err"}, 32'(resp_err), 32'h0);
    check_output({tag, "_mismatch"}, 32'(mismatch), 32'h0);
    check_output({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    logic [31:0] d; logic e;
    rst = 1'b1; ent_valid = 1'b0; ent_word = '0; ent_last = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

    vecs[0]  = mk("status_rst",   1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    vecs[1]  = mk("rec_cnt_rst",  1'b0, 8'h08, 32'h0, 32'h0, 1'b0);
    vecs[2]  = mk("cmp_cnt_rst",  1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
    vecs[3]  = mk("mm_info_rst",  1'b0, 8'h10, 32'h0, 32'h0, 1'b0);
    vecs[4]  = mk("mm_gold_rst",  1'b0, 8'h14, 32'h0, 32'h0, 1'b0);
    vecs[5]  = mk("mm_now_rst",   1'b0, 8'h18, 32'h0, 32'h0, 1'b0);
    vecs[6]  = mk("gaddr_rst",    1'b0, 8'h20, 32'h0, 32'h0, 1'b0);
    vecs[7]  = mk("gaddr_wr",     1'b1, 8'h20, 32'hDEAD0102, 32'h0, 1'b0);
    vecs[8]  = mk("gaddr_rd",     1'b0, 8'h20, 32'h0, 32'h0102, 1'b0);
    vecs[9]  = mk("gaddr_lowbit", 1'b0, 8'h23, 32'h0, 32'h0102, 1'b0);
    vecs[10] = mk("unmapped_rd",  1'b0, 8'h28, 32'h0, 32'h0, 1'b1);
    vecs[11] = mk("unmapped_wr",  1'b1, 8'hFC, 32'h5, 32'h0, 1'b1);
    vecs[12] = mk("ctrl_rd",      1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
`ifdef BOREAL_REPLAY_MASK_EN
    vecs[13] = mk("mask_rst",     1'b0, 8'h1C, 32'h0, 32'h0, 1'b0);
`else
    vecs[13] = mk("mask_absent",  1'b0, 8'h1C, 32'h0, 32'h0, 1'b1);
`endif
    vecs[14] = mk("ro_wr",        1'b1, 8'h04, 32'hFF, 32'h0, 1'b0);
    vecs[15] = mk("status_after", 1'b0, 8'h05, 32'h0, 32'h0, 1'b0);

    do_reset();
    check_reset_outputs("reset");
    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i]);

    // Record two entries, then replay identically.
    wr(8'h00, 32'h1);
    rd_check("status_record", 8'h04, 32'h1);
    wr(8'h00, 32'h2);
    rd_check("ctrl_ignored_in_rec", 8'h04, 32'h1);
    send_entry(32'h100, EW, 32'h0);
    send_entry(32'h200, EW, 32'h0);
    wr(8'h00, 32'h4);
    rd_check("rec_count_2", 8'h08, 32'h2);
    wr(8'h00, 32'h2);
    rd_check("status_compare", 8'h04, 32'h2);
    send_entry(32'h100, EW, 32'h0);
    send_entry(32'h200, EW, 32'h0);
    check_output("match_done", 32'(done), 32'h1);
    check_output("match_mismatch", 32'(mismatch), 32'h0);
    rd_check("match_cmp_count", 8'h0C, 32'h2);
    rd_check("match_status", 8'h04, 32'h08);

    // Entry 1 word 3 corrupted; a later corruption must not overwrite the capture.
    wr(8'h00, 32'h2);
    check_output("restart_clears_done", 32'(done), 32'h0);
    send_entry(32'h100, EW, 32'h0);
    for (int i = 0; i < EW; i++)
      send_word((i == 3) ? 32'hBAD : ((i == 5) ? 32'hCCC : 32'h200 + 32'(i)), i == EW - 1);
    check_output("mm_flag", 32'(mismatch), 32'h1);
    check_output("mm_done", 32'(done), 32'h1);
    rd_check("mm_info", 8'h10, 32'h0103);
    rd_check("mm_gold", 8'h14, 32'h203);
    rd_check("mm_now", 8'h18, 32'hBAD);
    rd_check("mm_status", 8'h04, 32'h0C);

`ifdef BOREAL_REPLAY_MASK_EN
    mmio(1'b1, 8'h1C, 32'h08, d, e);
    check_output("mask_wr_err", 32'(e), 32'h0);
    wr(8'h00, 32'h2);
    send_entry(32'h100, EW, 32'h0);
    send_entry(32'h200, 3, 32'hBAD);
    check_output("masked_mismatch", 32'(mismatch), 32'h0);
    check_output("masked_done", 32'(done), 32'h1);
    rd_check("mask_rd", 8'h1C, 32'h08);
    wr(8'h1C, 32'hFFFFFFFF);
    rd_check("mask_width", 8'h1C, 32'hFF);
    wr(8'h1C, 32'h0);
`else
    mmio(1'b1, 8'h1C, 32'h08, d, e);
    check_output("mask_wr_err", 32'(e), 32'h1);
    check_output("mask_wr_rdata", d, 32'h0);
`endif

    // Overflow with DEPTH=4: five entries recorded.
    do_reset();
    wr(8'h00, 32'h1);
    for (int k = 0; k < 5; k++) send_entry(32'hA000 + 32'(k * 16), EW, 32'h0);
    wr(8'h00, 32'h4);
    rd_check("ovf_rec_count", 8'h08, 32'h4);
    rd_check("ovf_status", 8'h04, 32'h10);
    wr(8'h20, 32'h0300);
    rd_check("gold_e3w0", 8'h24, 32'hA030);
    wr(8'h20, 32'h0307);
    rd_check("gold_e3w7", 8'h24, 32'hA037);
    wr(8'h20, 32'h0000);
    rd_check("gold_e0_kept", 8'h24, 32'hA000);
    wr(8'h20, 32'h0400);
    rd_check("gold_entry_oor", 8'h24, 32'h0);
    wr(8'h20, 32'h0008);
    rd_check("gold_word_oor", 8'h24, 32'h0);

    // Early ent_last on word 5 of 8.
    do_reset();
    wr(8'h00, 32'h1);
    for (int i = 0; i < 5; i++) send_word(32'hF00 + 32'(i), i == 4);
    rd_check("frame_early_status", 8'h04, 32'h21);
    rd_check("frame_early_count", 8'h08, 32'h1);
    send_word(32'hE00, 1'b0);
    wr(8'h00, 32'h4);
    wr(8'h20, 32'h0100);
    rd_check("frame_next_wi0", 8'h24, 32'hE00);
    wr(8'h20, 32'h0004);
    rd_check("frame_e0w4", 8'h24, 32'hF04);

    // Missing ent_last on the final word.
    do_reset();
    wr(8'h00, 32'h1);
    for (int i = 0; i < EW; i++) send_word(32'h700 + 32'(i), 1'b0);
    rd_check("frame_late_status", 8'h04, 32'h21);
    rd_check("frame_late_count", 8'h08, 32'h1);

    // Reset mid-record abandons the entry.
    do_reset();
    wr(8'h00, 32'h1);
    for (int i = 0; i < 3; i++) send_word(32'h300 + 32'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    rd_check("midrst_rec_count", 8'h08, 32'h0);
    rd_check("midrst_status", 8'h04, 32'h0);
    wr(8'h00, 32'h2);
    check_output("empty_compare_done", 32'(done), 32'h1);
    rd_check("empty_compare_status", 8'h04, 32'h08);
    wr(8'h00, 32'h1);
    send_entry(32'h400, EW, 32'h0);
    rd_check("post_rst_status", 8'h04, 32'h09);
    rd_check("post_rst_count", 8'h08, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
